datastore_dp_be: RTL and testbench

Parametrised true-dual-port byte-enabled data store for the L1 data arrays. It is the next generation of the current dual-port datastore. Additions over that block:
- generic data width
- explicit read strobes with read-valid outputs
- deterministic mixed-port collision resolution with forwarding
- stall input
- built-in zero-fill sequencer, run after reset and on request, so cache lines start clean.

---
 rtl/datastore_dp_be.sv | 164 ++++++++++++++++
 tb/tb_datastore_dp_be.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/datastore_dp_be.sv
// True-dual-port byte-enabled data store with zero-fill sequencer and read forwarding.
// Define DATASTORE_OUTREG_EN to add a second output register stage (read latency 2).
module datastore_dp_be #(
    parameter int unsigned AddrWidth = 6,
    parameter int unsigned DataWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [AddrWidth-1:0]   addr_a_i,
    input  logic [DataWidth-1:0]   data_a_i,
    input  logic [DataWidth/8-1:0] byte_enable_a_i,
    input  logic                   wr_a_i,
    input  logic                   rd_a_i,
    input  logic [AddrWidth-1:0]   addr_b_i,
    input  logic [DataWidth-1:0]   data_b_i,
    input  logic [DataWidth/8-1:0] byte_enable_b_i,
    input  logic                   wr_b_i,
    input  logic                   rd_b_i,
    input  logic                   stall_i,
    input  logic                   clear_i,
    output logic                   busy_o,
    output logic [DataWidth-1:0]   q_a_o,
    output logic                   q_valid_a_o,
    output logic [DataWidth-1:0]   q_b_o,
    output logic                   q_valid_b_o
);
    localparam int unsigned Depth = 2 ** AddrWidth;
    localparam int unsigned Lanes = DataWidth / 8;

    typedef enum logic {StFill, StReady} state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] cnt_q, cnt_d;
    logic                 fill_en, acc_en;
    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] fwd_a, fwd_b;
    logic [DataWidth-1:0] s1_q_a_q, s1_q_b_q;
    logic                 s1_v_a_q, s1_v_b_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_en = 1'b0;
        acc_en  = 1'b0;
        unique case (state_q)
            StFill: begin
                if (!stall_i) begin
                    fill_en = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (&cnt_q) state_d = StReady;
                end
            end
            StReady: begin
                // A clear still lets this cycle's accesses through.
                if (!stall_i) begin
                    acc_en = 1'b1;
                    if (clear_i) begin
                        state_d = StFill;
                        cnt_d   = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StFill;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o = (state_q == StFill);

    // Port B lanes are written first so port A overrides on shared lanes.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (fill_en) begin
                mem_q[cnt_q] <= '0;
            end else if (acc_en) begin
                for (int i = 0; i < Lanes; i++) begin
                    if (wr_b_i && byte_enable_b_i[i]) mem_q[addr_b_i][8*i +: 8] <= data_b_i[8*i +: 8];
                    if (wr_a_i && byte_enable_a_i[i]) mem_q[addr_a_i][8*i +: 8] <= data_a_i[8*i +: 8];
                end
            end
        end
    end

    // Post-write view of each read address, same precedence as the array write.
    always_comb begin
        fwd_a = mem_q[addr_a_i];
        fwd_b = mem_q[addr_b_i];
        for (int i = 0; i < Lanes; i++) begin
            if (wr_b_i && byte_enable_b_i[i]) begin
                if (addr_b_i == addr_a_i) fwd_a[8*i +: 8] = data_b_i[8*i +: 8];
                fwd_b[8*i +: 8] = data_b_i[8*i +: 8];
            end
            if (wr_a_i && byte_enable_a_i[i]) begin
                fwd_a[8*i +: 8] = data_a_i[8*i +: 8];
                if (addr_a_i == addr_b_i) fwd_b[8*i +: 8] = data_a_i[8*i +: 8];
            end
        end
    end

`ifdef DATASTORE_OUTREG_EN
    localparam logic StallClrS1 = 1'b0;
`else
    localparam logic StallClrS1 = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q_a_q <= '0;
            s1_q_b_q <= '0;
            s1_v_a_q <= 1'b0;
            s1_v_b_q <= 1'b0;
        end else if (!stall_i) begin
            s1_v_a_q <= acc_en & rd_a_i;
            s1_v_b_q <= acc_en & rd_b_i;
            if (acc_en && rd_a_i) s1_q_a_q <= fwd_a;
            if (acc_en && rd_b_i) s1_q_b_q <= fwd_b;
        end else if (StallClrS1) begin
            s1_v_a_q <= 1'b0;
            s1_v_b_q <= 1'b0;
        end
    end

`ifdef DATASTORE_OUTREG_EN
    logic [DataWidth-1:0] s2_q_a_q, s2_q_b_q;
    logic                 s2_v_a_q, s2_v_b_q;

    // Stage 1 holds a pending result through a stall; stage 2 shows no valid while stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_q_a_q <= '0;
            s2_q_b_q <= '0;
            s2_v_a_q <= 1'b0;
            s2_v_b_q <= 1'b0;
        end else if (!stall_i) begin
            s2_q_a_q <= s1_q_a_q;
            s2_q_b_q <= s1_q_b_q;
            s2_v_a_q <= s1_v_a_q;
            s2_v_b_q <= s1_v_b_q;
        end else begin
            s2_v_a_q <= 1'b0;
            s2_v_b_q <= 1'b0;
        end
    end

    assign q_a_o       = s2_q_a_q;
    assign q_b_o       = s2_q_b_q;
    assign q_valid_a_o = s2_v_a_q;
    assign q_valid_b_o = s2_v_b_q;
`else
    assign q_a_o       = s1_q_a_q;
    assign q_b_o       = s1_q_b_q;
    assign q_valid_a_o = s1_v_a_q;
    assign q_valid_b_o = s1_v_b_q;
`endif

endmodule

// File: tb/tb_datastore_dp_be.sv
// Self-checking bench for datastore_dp_be: directed vector table, fill/clear/reset
// sequences, and randomized traffic against a word-level reference model.
module tb_datastore_dp_be;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst, stall, clear;
    logic [5:0]  addr_a, addr_b;
    logic [31:0] data_a, data_b;
    logic [3:0]  be_a, be_b;
    logic        wr_a, rd_a, wr_b, rd_b;
    logic        busy, va, vb;
    logic [31:0] qa, qb;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    int          m_fill;
    logic [31:0] m_qa, m_qb;
    logic        m_va, m_vb;

    datastore_dp_be #(.AddrWidth(6), .DataWidth(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .addr_a_i(addr_a), .data_a_i(data_a), .byte_enable_a_i(be_a),
        .wr_a_i(wr_a), .rd_a_i(rd_a),
        .addr_b_i(addr_b), .data_b_i(data_b), .byte_enable_b_i(be_b),
        .wr_b_i(wr_b), .rd_b_i(rd_b),
        .stall_i(stall), .clear_i(clear), .busy_o(busy),
        .q_a_o(qa), .q_valid_a_o(va), .q_b_o(qb), .q_valid_b_o(vb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr_a, rd_a, wr_b, rd_b, stall;
        logic [5:0]  addr_a, addr_b;
        logic [31:0] data_a, data_b;
        logic [3:0]  be_a, be_b;
        logic [31:0] exp_qa, exp_qb;
        logic        exp_va, exp_vb;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(logic wa, logic [5:0] aa, logic [31:0] da, logic [3:0] ba,
                                logic ra, logic wb, logic [5:0] ab, logic [31:0] db,
                                logic [3:0] bb, logic rb, logic st, logic [31:0] eqa,
                                logic eva, logic [31:0] eqb, logic evb);
        vec_t v;
        v.wr_a = wa; v.addr_a = aa; v.data_a = da; v.be_a = ba; v.rd_a = ra;
        v.wr_b = wb; v.addr_b = ab; v.data_b = db; v.be_b = bb; v.rd_b = rb;
        v.stall = st; v.exp_qa = eqa; v.exp_va = eva; v.exp_qb = eqb; v.exp_vb = evb;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        rst = 0; stall = 0; clear = 0;
        wr_a = 0; rd_a = 0; addr_a = 0; data_a = 0; be_a = 0;
        wr_b = 0; rd_b = 0; addr_b = 0; data_b = 0; be_b = 0;
    endtask

    // Word-level behaviour: what the store holds and returns after this cycle's edge.
    task automatic model_step();
        logic [31:0] nm [DEPTH];
        if (rst) begin
            m_fill = DEPTH;
            m_qa = 0; m_qb = 0; m_va = 0; m_vb = 0;
        end else if (m_fill > 0) begin
            m_va = 0; m_vb = 0;
            if (!stall) begin
                m_mem[DEPTH - m_fill] = 0;
                m_fill--;
            end
        end else if (stall) begin
            m_va = 0; m_vb = 0;
        end else begin
            for (int k = 0; k < DEPTH; k++) nm[k] = m_mem[k];
            for (int i = 0; i < 4; i++)
                if (wr_b && be_b[i]) nm[addr_b][8*i +: 8] = data_b[8*i +: 8];
            for (int i = 0; i < 4; i++)
                if (wr_a && be_a[i]) nm[addr_a][8*i +: 8] = data_a[8*i +: 8];
            m_va = rd_a; m_vb = rd_b;
            if (rd_a) m_qa = nm[addr_a];
            if (rd_b) m_qb = nm[addr_b];
            for (int k = 0; k < DEPTH; k++) m_mem[k] = nm[k];
            if (clear) m_fill = DEPTH;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles with busy high, starting from the current observation.
    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            if (!busy) break;
            n++;
            cycle();
        end
    endtask

    int n;

    initial begin
        for (int k = 0; k < DEPTH; k++) m_mem[k] = 0;
        m_fill = 0; m_qa = 0; m_qb = 0; m_va = 0; m_vb = 0;

        vecs[0]  = mk(1, 5, 32'hAABBCCDD, 4'b0101, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 5, 0, 0, 1, 0, 0, 0, 32'h00BB00DD, 1);
        vecs[2]  = mk(1, 9, 32'h11223344, 4'b1111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00BB00DD, 0);
        vecs[3]  = mk(1, 9, 32'hFFEEDDCC, 4'b1100, 0, 0, 9, 0, 0, 1, 0, 0, 0, 32'hFFEE3344, 1);
        vecs[4]  = mk(1, 3, 32'hA1A2A3A4, 4'b0011, 0, 1, 3, 32'hB1B2B3B4, 4'b0110, 0, 0,
                      0, 0, 32'hFFEE3344, 0);
        vecs[5]  = mk(0, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h00B2A3A4, 1, 32'hFFEE3344, 0);
        for (int i = 6; i < 9; i++)
            vecs[i] = mk(0, 5, 0, 0, 1, 1, 5, 32'h12345678, 4'b1111, 0, 1,
                         32'h00B2A3A4, 0, 32'hFFEE3344, 0);
        vecs[9]  = mk(0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h00BB00DD, 1, 32'hFFEE3344, 0);
        vecs[10] = mk(1, 7, 32'h55667788, 4'b0011, 1, 0, 0, 0, 0, 0, 0,
                      32'h00007788, 1, 32'hFFEE3344, 0);
        vecs[11] = mk(0, 9, 0, 0, 1, 0, 3, 0, 0, 1, 0, 32'hFFEE3344, 1, 32'h00B2A3A4, 1);
        vecs[12] = mk(1, 5, 32'hFFFFFFFF, 4'b0000, 0, 0, 5, 0, 0, 1, 0,
                      32'hFFEE3344, 0, 32'h00BB00DD, 1);

        // Reset and initial fill
        idle();
        rst = 1;
        cycle();
        rst = 0;
        check("reset_busy", busy, 1);
        check("reset_qa", qa, 0);
        check("reset_qb", qb, 0);
        check("reset_va", va, 0);
        check("reset_vb", vb, 0);
        count_busy(n);
        check("fill_busy_cycles", n, 64);

        rd_a = 1; addr_a = 6'h3F;
        cycle();
        rd_a = 0;
        check("read_3f_qa", qa, 0);
        check("read_3f_va", va, 1);
        cycle();
        check("read_3f_va_pulse", va, 0);

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            wr_a = vecs[i].wr_a; addr_a = vecs[i].addr_a; data_a = vecs[i].data_a;
            be_a = vecs[i].be_a; rd_a = vecs[i].rd_a;
            wr_b = vecs[i].wr_b; addr_b = vecs[i].addr_b; data_b = vecs[i].data_b;
            be_b = vecs[i].be_b; rd_b = vecs[i].rd_b; stall = vecs[i].stall;
            cycle();
            check($sformatf("vec%0d_qa", i), qa, vecs[i].exp_qa);
            check($sformatf("vec%0d_va", i), va, vecs[i].exp_va);
            check($sformatf("vec%0d_qb", i), qb, vecs[i].exp_qb);
            check($sformatf("vec%0d_vb", i), vb, vecs[i].exp_vb);
            check($sformatf("vec%0d_busy", i), busy, 0);
        end
        idle();

        // Clear in READY, then every word reads back zero
        clear = 1;
        cycle();
        clear = 0;
        count_busy(n);
        check("clear_busy_cycles", n, 64);
        for (int a = 0; a < DEPTH; a++) begin
            rd_a = 1; addr_a = 6'(a);
            cycle();
            check($sformatf("zero_word%0d", a), {va, qa}, {1'b1, 32'h0});
        end
        idle();

        // Reset at fill count 20 restarts the fill
        clear = 1;
        cycle();
        clear = 0;
        for (int k = 0; k < 20; k++) cycle();
        check("midfill_busy", busy, 1);
        rst = 1;
        cycle();
        rst = 0;
        count_busy(n);
        check("rst_midfill_busy_cycles", n, 64);

        // Randomized traffic against the reference model
        for (int k = 0; k < 1500; k++) begin
            rst    = ($urandom_range(0, 499) == 0);
            clear  = ($urandom_range(0, 99) == 0);
            stall  = ($urandom_range(0, 99) < 15);
            wr_a   = $urandom_range(0, 1) == 1;
            rd_a   = $urandom_range(0, 1) == 1;
            wr_b   = $urandom_range(0, 1) == 1;
            rd_b   = $urandom_range(0, 1) == 1;
            addr_a = 6'($urandom_range(0, 7));
            addr_b = 6'($urandom_range(0, 7));
            data_a = $urandom;
            data_b = $urandom;
            be_a   = 4'($urandom_range(0, 15));
            be_b   = 4'($urandom_range(0, 15));
            cycle();
            check("rnd_busy", busy, (m_fill > 0) ? 1 : 0);
            check("rnd_va", va, m_va);
            check("rnd_vb", vb, m_vb);
            check("rnd_qa", qa, m_qa);
            check("rnd_qb", qb, m_qb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
